rom_stream_reader: RTL and testbench

Upstream controller for the registered single-port ROM. On a start command it walks a contiguous address range, drives the ROM address port, absorbs the ROM's one-cycle read latency, and presents the returned words as a valid/ready stream with full backpressure support. The block owns the ROM `addr` input and consumes its `data_out`. The 2-entry output buffer guarantees no word is lost when the consumer stalls.

---
 rtl/rom_stream_reader.sv | 133 +++++++++++++
 tb/tb_rom_stream_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a contiguous ROM address range after a start
// command, absorbs the ROM's one-cycle read latency and presents the returned
// words as a valid/ready stream through a 2-entry buffer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; a zero-length start only pulses done
// S_RUN   | issuing reads while words remain and the buffer has room
// S_DRAIN | all reads issued; waiting for the in-flight read and buffer to empty
module rom_stream_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   length_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          count_q, count_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   mem_q [2];

    logic                pop;
    logic                push;
    logic                issue;
    logic [2:0]          occ;

    assign rom_addr_o  = cur_addr_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

    // Next-state, issue decision and buffer bookkeeping.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        pop  = out_valid_o & out_ready_i;
        push = inflight_q;
        // Occupancy the buffer will have once the in-flight word lands and
        // this cycle's pop (if any) leaves; one more read fits only if <= 1.
        occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == S_RUN) && (remaining_q != '0) && (occ <= 3'd1);

        inflight_d = issue;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (length_i != '0) begin
                        state_d     = S_RUN;
                        cur_addr_d  = base_addr_i;
                        remaining_d = length_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W+1)'(1);
                    if (remaining_q == (ADDR_W+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((count_d == 2'd0) && !inflight_d) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            done_q      <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            done_q      <= done_d;
            if (push) begin
                mem_q[wr_ptr_q] <= rom_data_i;
            end
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Testbench for rom_stream_reader: registered ROM model, table of transfers
// checked through a word scoreboard, plus a hand-written mid-transfer reset.
module tb_rom_stream_reader;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       start_i;
    logic [7:0] base_addr_i;
    logic [8:0] length_i;
    logic [7:0] rom_addr_o;
    logic [7:0] rom_data_i;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       busy_o;
    logic       done_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] base;
        int         len;
        int         mode;       // 0: ready high, 1: random ready, 2: ready low in cycles 3..7
        int         exp_first;  // first out_valid cycle, -1 for never
        int         exp_done;   // done cycle, 0 when not fixed in advance
    } vec_t;

    rom_stream_reader #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .length_i    (length_i),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Registered single-port ROM, mem[i] = i ^ A5.
    always @(posedge clk_i) begin
        rom_data_i <= rom_addr_o ^ 8'hA5;
    end

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return !(c >= 3 && c <= 7);
        endcase
    endfunction

    // Entered at a negedge in the cycle that carries start (cycle 0); returns
    // at the negedge of the done cycle so the next call can start right there.
    task automatic run_xfer(input vec_t v);
        int         c;
        int         first_v;
        int         last_pop;
        int         limit;
        bit         fin;
        bit         prev_stall;
        bit         got_done;
        logic [7:0] prev_data;
        logic [7:0] a;
        logic [7:0] w;

        start_i     = 1'b1;
        base_addr_i = v.base;
        length_i    = 9'(v.len);
        out_ready_i = ready_for(v.mode, 0);
        for (int i = 0; i < v.len; i++) begin
            a = 8'(v.base + 8'(i));
            exp_q.push_back(a ^ 8'hA5);
        end
        c          = 0;
        first_v    = -1;
        last_pop   = -1;
        fin        = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        got_done   = 1'b0;
        limit      = 4 * v.len + 40;

        while (c < limit) begin
            @(negedge clk_i);
            c++;
            // A second start while busy must be ignored.
            start_i     = (c == 2) && (v.len != 0);
            base_addr_i = (c == 2) ? 8'h55 : v.base;
            length_i    = (c == 2) ? 9'd5 : 9'(v.len);
            out_ready_i = ready_for(v.mode, c);

            if (out_valid_o && first_v < 0) first_v = c;
            if (prev_stall) begin
                check_eq("stall_valid_hold", int'(out_valid_o), 1);
                check_eq("stall_data_hold", int'(out_data_o), int'(prev_data));
            end
            check_eq("busy", int'(busy_o), int'((v.len != 0) && !fin));

            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_word", int'(out_data_o), -1);
                end else begin
                    w = exp_q.pop_front();
                    check_eq("word", int'(out_data_o), int'(w));
                end
                last_pop = c;
            end
            if (done_o) begin
                got_done = 1'b1;
                check_eq("valid_at_done", int'(out_valid_o), 0);
                break;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            if (exp_q.size() == 0 && last_pop == c) fin = 1'b1;
        end

        start_i     = 1'b0;
        base_addr_i = v.base;
        length_i    = 9'(v.len);
        check_eq("done_seen", int'(got_done), 1);
        check_eq("done_cycle", c, (v.len == 0) ? 1 : last_pop + 1);
        if (v.exp_done != 0) check_eq("done_cycle_fixed", c, v.exp_done);
        check_eq("first_valid", first_v, v.exp_first);
        check_eq("words_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{base: 8'h10, len: 4,   mode: 0, exp_first: 3,  exp_done: 7};
        vecs[1] = '{base: 8'h10, len: 4,   mode: 2, exp_first: 3,  exp_done: 12};
        vecs[2] = '{base: 8'hFE, len: 4,   mode: 0, exp_first: 3,  exp_done: 7};
        vecs[3] = '{base: 8'h00, len: 0,   mode: 0, exp_first: -1, exp_done: 1};
        vecs[4] = '{base: 8'h80, len: 256, mode: 1, exp_first: 3,  exp_done: 0};
        vecs[5] = '{base: 8'h33, len: 1,   mode: 0, exp_first: 3,  exp_done: 4};
        vecs[6] = '{base: 8'hF0, len: 300, mode: 1, exp_first: 3,  exp_done: 0};
        vecs[7] = '{base: 8'h7F, len: 2,   mode: 2, exp_first: 3,  exp_done: 0};

        rst_n_i     = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        length_i    = '0;
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_eq("rst_rom_addr", int'(rom_addr_o), 0);
        check_eq("rst_valid", int'(out_valid_o), 0);
        check_eq("rst_busy", int'(busy_o), 0);
        check_eq("rst_done", int'(done_o), 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Back-to-back: each transfer starts in the done cycle of the previous one.
        for (int k = 0; k < 8; k++) begin
            run_xfer(vecs[k]);
        end
        @(negedge clk_i);
        check_eq("done_one_cycle", int'(done_o), 0);

        // Mid-transfer reset: stall the consumer, then reset in cycle 4.
        start_i     = 1'b1;
        base_addr_i = 8'h10;
        length_i    = 9'd8;
        out_ready_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (c == 3) begin
                check_eq("pre_rst_valid", int'(out_valid_o), 1);
                check_eq("pre_rst_data", int'(out_data_o), int'(8'h10 ^ 8'hA5));
            end
            if (c == 4) begin
                check_eq("pre_rst_busy", int'(busy_o), 1);
                rst_n_i = 1'b0;
            end
        end
        @(negedge clk_i);
        check_eq("mid_rst_rom_addr", int'(rom_addr_o), 0);
        check_eq("mid_rst_valid", int'(out_valid_o), 0);
        check_eq("mid_rst_data", int'(out_data_o), 0);
        check_eq("mid_rst_busy", int'(busy_o), 0);
        check_eq("mid_rst_done", int'(done_o), 0);
        rst_n_i     = 1'b1;
        out_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check_eq("post_rst_done", int'(done_o), 0);
            check_eq("post_rst_busy", int'(busy_o), 0);
        end
        run_xfer(vecs[0]);
        @(negedge clk_i);
        check_eq("final_done_low", int'(done_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
